z80_bus_sync: RTL and testbench
===============================

Z80_BUS_SYNC -- requirements
Module: z80_bus_sync

Interface
REQ-001 SHALL have parameter QUAL_CYCLES, default 2, meaning the number of consecutive synchronized clocks a bus condition must hold before acceptance (legal range 1..15).
REQ-002 SHALL have port CLK, input, 1, FPGA system clock.
REQ-003 SHALL have port RST, input, 1, FPGA-side reset. It is asynchronous and active-high.
REQ-004 SHALL have port A, input, 16, Z80 address bus (asynchronous to CLK).
REQ-005 SHALL have port D, input, 8, Z80 data bus (asynchronous).
REQ-006 SHALL have ports RD, WR, IORQ, MRQ, M1, input, 1 each, Z80 control strobes; all are active-low and asynchronous.
REQ-007 SHALL have port CYC_STB, output, 1, one-clock pulse marking an accepted bus cycle.
REQ-008 SHALL have port CYC_TYPE, output, 2, encoded as 00 IO write, 01 IO read, 10 mem write, 11 mem read.
REQ-009 SHALL have port CYC_A, output, 16, captured address.
REQ-010 SHALL have port CYC_D, output, 8, captured data for writes; 0 for reads.
REQ-011 SHALL have port INTA_STB, output, 1, one-clock pulse marking an accepted interrupt acknowledge.
REQ-012 SHALL have port BUSY, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL pass RD, WR, IORQ, MRQ and M1 each through a 2-FF synchronizer. A and D SHALL go through an equal-depth 2-stage register pipeline so that data is aligned with the synchronized controls (s2).
REQ-014 SHALL classify each clock from the s2 values, with this priority:
  - INTA: IORQ=0 and M1=0.
  - IO: IORQ=0, M1=1, exactly one of RD/WR =0.
  - MEM: MRQ=0, IORQ=1, exactly one of RD/WR =0.
  - Otherwise NONE. This covers refresh (MRQ=0, RD=WR=1), RD=WR=0, and idle.
REQ-015 SHALL treat IORQ=0 together with MRQ=0 as IO (or INTA if M1=0). MEM is never reported while IORQ=0.
REQ-016 SHALL implement FSM states IDLE, QUAL, STROBE, HOLD.
REQ-017 IDLE->QUAL SHALL occur when the class is not NONE. The class is latched and the 4-bit counter is set to 1.
REQ-018 In QUAL, if the class equals the latched class, the counter SHALL increment. If the class differs (including NONE), the FSM SHALL return to IDLE with no strobe.
REQ-019 When the counter reaches QUAL_CYCLES with the class still matching, the FSM SHALL enter STROBE on that edge. It SHALL register CYC_A and CYC_D from the aligned pipeline and CYC_TYPE from the class.
REQ-020 With QUAL_CYCLES=1, the FSM SHALL go directly from IDLE to STROBE.
REQ-021 In STROBE, CYC_STB (or INTA_STB for the INTA class) SHALL be high for exactly one cycle. The FSM SHALL then enter HOLD unconditionally.
REQ-022 In HOLD, the FSM SHALL remain until s2 of RD, WR, IORQ and MRQ are all 1 on one edge, then go to IDLE. No second strobe SHALL occur for the same bus cycle, however long it is held.
REQ-023 Latency: for a control edge first sampled at CLK edge k, the strobe SHALL be high in the cycle after edge k+QUAL_CYCLES+1 (cycle after edge k+3 at default).
REQ-024 CYC_A, CYC_D and CYC_TYPE SHALL hold their values until the next STROBE entry.
REQ-025 For INTA, CYC_A, CYC_D and CYC_TYPE SHALL be left unchanged.
REQ-026 For read types, CYC_D SHALL be loaded with 0.
REQ-027 CYC_STB and INTA_STB SHALL never be high in the same cycle.
REQ-028 Glitch rule: a class lasting fewer than QUAL_CYCLES synchronized clocks SHALL produce no strobe.
REQ-029 Back-to-back rule: a new cycle SHALL be accepted only after passing through IDLE.

Reset
REQ-030 While RST=1 (asynchronously):
  - State SHALL be IDLE and the counter 0.
  - CYC_STB, INTA_STB and BUSY SHALL be 0.
  - CYC_TYPE, CYC_A and CYC_D SHALL be 0.
  - Control synchronizer flops SHALL be 1 (deasserted); A/D pipeline SHALL be 0.
REQ-031 Reset asserted mid-cycle SHALL abort the cycle with no strobe.
REQ-032 A bus cycle still held after reset release SHALL be treated as new and strobed if it satisfies the qualification rules.

Verification
REQ-033 IO write: A=0x00C0, D=0x5A, IORQ=WR=0 held 6 clocks -> one CYC_STB, CYC_TYPE=00, CYC_A=0x00C0, CYC_D=0x5A, at cycle after edge k+3.
REQ-034 Mem read: MRQ=RD=0, A=0x8123 held 10 clocks -> exactly one CYC_STB, TYPE=11, CYC_D=0x00. BUSY stays high until release + 1 edge.
REQ-035 Glitch and refresh:
  - IORQ=WR=0 for 1 clock (QUAL_CYCLES=2) -> no strobe.
  - MRQ=0 with RD=WR=1 -> no strobe.
REQ-036 INTA: IORQ=M1=0 held 5 clocks -> INTA_STB pulse only. CYC_* outputs are unchanged from the prior write.
REQ-037 Reset mid-QUAL: RST pulsed while in QUAL -> no strobe, all outputs 0. A bus write still held after release -> strobe 4 edges after release (default).
REQ-038 Illegal: RD=WR=0 with IORQ=0 -> no strobe, BUSY stays 0.

Source files
------------

// File: rtl/z80_bus_sync.sv
// Z80 bus cycle synchronizer: brings asynchronous Z80 strobes into the CLK domain,
// qualifies each bus cycle for QUAL_CYCLES clocks and emits one strobe per cycle.
module z80_bus_sync #(
  parameter int unsigned QUAL_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  input  logic        RD,
  input  logic        WR,
  input  logic        IORQ,
  input  logic        MRQ,
  input  logic        M1,
  output logic        CYC_STB,
  output logic [1:0]  CYC_TYPE,
  output logic [15:0] CYC_A,
  output logic [7:0]  CYC_D,
  output logic        INTA_STB,
  output logic        BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_QUAL, ST_STROBE, ST_HOLD} state_t;
  typedef enum logic [2:0] {CLS_NONE, CLS_IO_WR, CLS_IO_RD, CLS_MEM_WR, CLS_MEM_RD, CLS_INTA} cls_t;

  localparam logic [3:0] QUAL_LIM = 4'(QUAL_CYCLES);

  // Control bit order: {M1, MRQ, IORQ, WR, RD}
  logic [4:0]  ctl_s1_r, ctl_s2_r;
  logic [15:0] a_p1_r, a_p2_r;
  logic [7:0]  d_p1_r, d_p2_r;
  logic        rd_s, wr_s, iorq_s, mrq_s, m1_s;
  cls_t        cls_s, cls_r, cls_nxt_s;
  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;

  function automatic logic [1:0] cls_type(input cls_t c);
    case (c)
      CLS_IO_WR:  cls_type = 2'b00;
      CLS_IO_RD:  cls_type = 2'b01;
      CLS_MEM_WR: cls_type = 2'b10;
      CLS_MEM_RD: cls_type = 2'b11;
      default:    cls_type = 2'b00;
    endcase
  endfunction

  function automatic logic cls_is_write(input cls_t c);
    cls_is_write = (c == CLS_IO_WR) || (c == CLS_MEM_WR);
  endfunction

  // Two-flop synchronizers for strobes, matching two-stage pipeline for A/D
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctl_s1_r <= 5'b11111;
      ctl_s2_r <= 5'b11111;
      a_p1_r   <= 16'h0000;
      a_p2_r   <= 16'h0000;
      d_p1_r   <= 8'h00;
      d_p2_r   <= 8'h00;
    end else begin
      ctl_s1_r <= {M1, MRQ, IORQ, WR, RD};
      ctl_s2_r <= ctl_s1_r;
      a_p1_r   <= A;
      a_p2_r   <= a_p1_r;
      d_p1_r   <= D;
      d_p2_r   <= d_p1_r;
    end
  end

  assign {m1_s, mrq_s, iorq_s, wr_s, rd_s} = ctl_s2_r;

  // Classify the synchronized bus; IORQ outranks MRQ so MEM never appears with IORQ low
  always_comb begin
    cls_s = CLS_NONE;
    if (!iorq_s && !m1_s) begin
      cls_s = CLS_INTA;
    end else if (!iorq_s) begin
      if (!rd_s && wr_s) begin
        cls_s = CLS_IO_RD;
      end else if (rd_s && !wr_s) begin
        cls_s = CLS_IO_WR;
      end else begin
        cls_s = CLS_NONE;
      end
    end else if (!mrq_s) begin
      if (!rd_s && wr_s) begin
        cls_s = CLS_MEM_RD;
      end else if (rd_s && !wr_s) begin
        cls_s = CLS_MEM_WR;
      end else begin
        cls_s = CLS_NONE;
      end
    end else begin
      cls_s = CLS_NONE;
    end
  end

  // Next-state logic for qualification FSM
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cls_nxt_s   = cls_r;
    case (state_r)
      ST_IDLE: begin
        if (cls_s != CLS_NONE) begin
          cls_nxt_s = cls_s;
          cnt_nxt_s = 4'd1;
          if (QUAL_LIM <= 4'd1) begin
            state_nxt_s = ST_STROBE;
          end else begin
            state_nxt_s = ST_QUAL;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_QUAL: begin
        if (cls_s == cls_r) begin
          cnt_nxt_s = cnt_r + 4'd1;
          if (cnt_nxt_s >= QUAL_LIM) begin
            state_nxt_s = ST_STROBE;
          end else begin
            state_nxt_s = ST_QUAL;
          end
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      ST_STROBE: begin
        state_nxt_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (rd_s && wr_s && iorq_s && mrq_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State register and registered outputs; capture happens only on STROBE entry
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      cls_r    <= CLS_NONE;
      CYC_STB  <= 1'b0;
      INTA_STB <= 1'b0;
      BUSY     <= 1'b0;
      CYC_TYPE <= 2'b00;
      CYC_A    <= 16'h0000;
      CYC_D    <= 8'h00;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      cls_r    <= cls_nxt_s;
      CYC_STB  <= (state_nxt_s == ST_STROBE) && (cls_nxt_s != CLS_INTA);
      INTA_STB <= (state_nxt_s == ST_STROBE) && (cls_nxt_s == CLS_INTA);
      BUSY     <= (state_nxt_s != ST_IDLE);
      if ((state_nxt_s == ST_STROBE) && (cls_nxt_s != CLS_INTA)) begin
        CYC_TYPE <= cls_type(cls_nxt_s);
        CYC_A    <= a_p2_r;
        CYC_D    <= cls_is_write(cls_nxt_s) ? d_p2_r : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_sync.sv
// Directed bench for z80_bus_sync: table of bus transactions plus reset corner cases.
module tb_z80_bus_sync;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] A;
  logic [7:0]  D;
  logic        RD, WR, IORQ, MRQ, M1;
  logic        CYC_STB, INTA_STB, BUSY;
  logic [1:0]  CYC_TYPE;
  logic [15:0] CYC_A;
  logic [7:0]  CYC_D;
  logic        q1_stb, q1_inta, q1_busy;
  logic [1:0]  q1_type;
  logic [15:0] q1_a;
  logic [7:0]  q1_d;

  always #5 CLK = ~CLK;

  z80_bus_sync dut (
    .CLK(CLK), .RST(RST), .A(A), .D(D), .RD(RD), .WR(WR), .IORQ(IORQ), .MRQ(MRQ), .M1(M1),
    .CYC_STB(CYC_STB), .CYC_TYPE(CYC_TYPE), .CYC_A(CYC_A), .CYC_D(CYC_D),
    .INTA_STB(INTA_STB), .BUSY(BUSY)
  );

  z80_bus_sync #(.QUAL_CYCLES(1)) dut_q1 (
    .CLK(CLK), .RST(RST), .A(A), .D(D), .RD(RD), .WR(WR), .IORQ(IORQ), .MRQ(MRQ), .M1(M1),
    .CYC_STB(q1_stb), .CYC_TYPE(q1_type), .CYC_A(q1_a), .CYC_D(q1_d),
    .INTA_STB(q1_inta), .BUSY(q1_busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rd, wr, iorq, mrq, m1;
    int          hold;
    int          exp_stb;
    int          exp_inta;
    int          exp_q1;
    int          exp_last_busy;
    logic [1:0]  exp_type;
    logic [15:0] exp_a;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vecs[9];
  int   n_vec = 0;
  int   n_checks = 0;
  int   miscompares = 0;
  int   idx, n_stb, n_inta, first_idx, n_q1, first_q1, last_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    RD = 1'b1; WR = 1'b1; IORQ = 1'b1; MRQ = 1'b1; M1 = 1'b1;
  endtask

  task automatic clear_mon();
    idx = 0; n_stb = 0; n_inta = 0; first_idx = -1; n_q1 = 0; first_q1 = -1; last_busy = -1;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    if (CYC_STB) n_stb++;
    if (INTA_STB) n_inta++;
    if ((CYC_STB || INTA_STB) && first_idx < 0) first_idx = idx;
    if (q1_stb || q1_inta) begin
      n_q1++;
      if (first_q1 < 0) first_q1 = idx;
    end
    if (BUSY) last_busy = idx;
    if (CYC_STB && INTA_STB) check("both_strobes", 32'd1, 32'd0);
    idx++;
  endtask

  initial begin
    //                a        d      rd    wr    iorq  mrq   m1  hold stb inta q1 lastbusy type   exp_a    exp_d
    vecs[0] = '{16'h00C0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6, 1, 0, 1, 7, 2'b00, 16'h00C0, 8'h5A};
    vecs[1] = '{16'h8123, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10, 1, 0, 1, 11, 2'b11, 16'h8123, 8'h00};
    vecs[2] = '{16'h1111, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 0, 1, 2, 2'b11, 16'h8123, 8'h00};
    vecs[3] = '{16'h2222, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4, 0, 0, 0, -1, 2'b11, 16'h8123, 8'h00};
    vecs[4] = '{16'h4000, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1, 0, 1, 4, 2'b10, 16'h4000, 8'hC3};
    vecs[5] = '{16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5, 0, 1, 1, 6, 2'b10, 16'h4000, 8'hC3};
    vecs[6] = '{16'h00FE, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1, 0, 1, 5, 2'b01, 16'h00FE, 8'h00};
    vecs[7] = '{16'h3333, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5, 0, 0, 0, -1, 2'b01, 16'h00FE, 8'h00};
    vecs[8] = '{16'h1234, 8'h56, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1, 0, 1, 5, 2'b00, 16'h1234, 8'h56};

    A = 16'h0000; D = 8'h00; bus_idle();
    RST = 1'b1;
    clear_mon();
    repeat (3) step();
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    check("reset_stb", {30'd0, CYC_STB, INTA_STB}, 32'd0);
    check("reset_type", {30'd0, CYC_TYPE}, 32'd0);
    check("reset_a", {16'd0, CYC_A}, 32'd0);
    check("reset_d", {24'd0, CYC_D}, 32'd0);
    RST = 1'b0;
    repeat (3) step();

    for (int v = 0; v < 9; v++) begin
      n_vec++;
      clear_mon();
      A = vecs[v].a; D = vecs[v].d;
      RD = vecs[v].rd; WR = vecs[v].wr; IORQ = vecs[v].iorq; MRQ = vecs[v].mrq; M1 = vecs[v].m1;
      repeat (vecs[v].hold) step();
      bus_idle();
      A = 16'hDEAD; D = 8'hBE;
      repeat (8) step();
      check($sformatf("v%0d_stb_count", v), n_stb, vecs[v].exp_stb);
      check($sformatf("v%0d_inta_count", v), n_inta, vecs[v].exp_inta);
      if (vecs[v].exp_stb + vecs[v].exp_inta > 0)
        check($sformatf("v%0d_latency", v), first_idx, 32'd3);
      check($sformatf("v%0d_q1_count", v), n_q1, vecs[v].exp_q1);
      if (vecs[v].exp_q1 > 0)
        check($sformatf("v%0d_q1_latency", v), first_q1, 32'd2);
      check($sformatf("v%0d_last_busy", v), last_busy, vecs[v].exp_last_busy);
      check($sformatf("v%0d_type", v), {30'd0, CYC_TYPE}, {30'd0, vecs[v].exp_type});
      check($sformatf("v%0d_a", v), {16'd0, CYC_A}, {16'd0, vecs[v].exp_a});
      check($sformatf("v%0d_d", v), {24'd0, CYC_D}, {24'd0, vecs[v].exp_d});
      check($sformatf("v%0d_busy_end", v), {31'd0, BUSY}, 32'd0);
    end

    // Reset pulsed while qualifying, bus write still held afterwards
    n_vec++;
    clear_mon();
    A = 16'hBEEF; D = 8'h11; IORQ = 1'b0; WR = 1'b0;
    repeat (3) step();
    check("midrst_in_qual", {31'd0, BUSY}, 32'd1);
    check("midrst_no_stb", n_stb + n_inta, 32'd0);
    #1 RST = 1'b1;
    #1;
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    check("midrst_stb", {30'd0, CYC_STB, INTA_STB}, 32'd0);
    check("midrst_a", {16'd0, CYC_A}, 32'd0);
    check("midrst_d", {24'd0, CYC_D}, 32'd0);
    check("midrst_type", {30'd0, CYC_TYPE}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    clear_mon();
    repeat (6) step();
    check("postrst_count", n_stb, 32'd1);
    check("postrst_latency", first_idx, 32'd3);
    check("postrst_a", {16'd0, CYC_A}, 32'h0000BEEF);
    check("postrst_d", {24'd0, CYC_D}, 32'h11);
    check("postrst_type", {30'd0, CYC_TYPE}, 32'd0);
    bus_idle();
    repeat (6) step();
    check("postrst_busy_end", {31'd0, BUSY}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
